// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multiply/divide unit.
//   md_op_e    - E-stage request codes (3 bits; codes 0 and 7 are no-ops)
//   md_state_e - sequencer FSM states
//   MD_MULT_CYCLES_DEF / MD_DIV_CYCLES_DEF - default datapath latencies
//   is_muldiv()  - true for the codes that occupy the datapath
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  function automatic logic is_muldiv(input logic [2:0] o);
    return (o == MD_MULT) || (o == MD_MULTU) || (o == MD_DIV) || (o == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit multiply/divide result generator.
//   op       in  3   operation code (mdu_pkg::md_op_e)
//   a        in  32  operand A (rs)
//   b        in  32  operand B (rt)
//   res_hi   out 32  HI result (product upper / remainder)
//   res_lo   out 32  LO result (product lower / quotient)
//   div_zero out 1   DIV/DIVU with b == 0; result must not be committed
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_b;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'b0, a} * {32'b0, b};

    // Signed divide is done on magnitudes so the quotient truncates toward
    // zero and the remainder follows the dividend sign; DIVU uses the raw
    // operands through the same unsigned divider.
    signed_div = (op == MD_DIV);
    a_neg      = signed_div & a[31];
    b_neg      = signed_div & b[31];
    a_mag      = a_neg ? -a : a;
    b_mag      = b_neg ? -b : b;
    div_b      = (b_mag == '0) ? 32'd1 : b_mag;
    q_u        = a_mag / div_b;
    r_u        = a_mag % div_b;
    quot       = (a_neg ^ b_neg) ? -q_u : q_u;
    rem        = a_neg ? -r_u : r_u;

    res_hi   = '0;
    res_lo   = '0;
    div_zero = 1'b0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV, MD_DIVU: begin
        res_hi   = rem;
        res_lo   = quot;
        div_zero = (b == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multiply/divide sequencer owning HI/LO for the pipelined core.
//   clk, rst     clock / async active-high reset
//   start, op    E-stage request valid and operation code
//   rs_val       operand A, also MTHI/MTLO data
//   rt_val       operand B
//   d_uses_md    instruction in D touches the mult/div unit
//   busy         operation in flight (state == RUN)
//   stall        stall request to the hazard unit (combinational)
//   hi, lo       architectural HI/LO registers
// The result is computed at the start edge and held in pending registers;
// the busy counter only models latency and commits on its 1->0 edge.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  md_state_e   state;
  logic [CW-1:0] cnt;
  logic [31:0] pending_hi;
  logic [31:0] pending_lo;
  logic        pending_valid;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_zero;
  logic        start_md;
  logic [CW-1:0] cnt_load;

  mdu_arith u_arith (
    .op       (op),
    .a        (rs_val),
    .b        (rt_val),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_comb begin
    start_md = start & is_muldiv(op);
    cnt_load = ((op == MD_DIV) || (op == MD_DIVU)) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      hi            <= '0;
      lo            <= '0;
      pending_hi    <= '0;
      pending_lo    <= '0;
      pending_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_md) begin
            pending_hi    <= res_hi;
            pending_lo    <= res_lo;
            pending_valid <= ~div_zero;
            cnt           <= cnt_load;
            state         <= ST_RUN;
          end else if (start && (op == MD_MTHI)) begin
            hi <= rs_val;
          end else if (start && (op == MD_MTLO)) begin
            lo <= rs_val;
          end
        end
        ST_RUN: begin
          // Requests arriving while RUN are dropped; the stall keeps
          // correct code from ever issuing one.
          if (cnt <= CW'(1)) begin
            cnt   <= '0;
            state <= ST_IDLE;
            if (pending_valid) begin
              hi <= pending_hi;
              lo <= pending_lo;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = (state == ST_RUN);
    stall = d_uses_md & (busy | start_md);
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_uses_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .d_uses_md (d_uses_md),
    .busy      (busy),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for a single cycle; returns at the falling edge
  // after the sampling edge E0.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op     = o;
    rs_val = a;
    rt_val = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    op     = MD_NOP;
  endtask

  // Number of falling edges at which busy is seen high, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    start = 1'b0; op = MD_NOP; rs_val = '0; rt_val = '0; d_uses_md = 1'b0; rst = 1'b0;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp %h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
  endtask

  task automatic test_mult;
    int n;
    issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
    checks++; if (busy !== 1'b1 || hi !== 32'h0) begin errors++; $display("FAIL mult_early busy %b hi %h exp busy 1 hi 0", busy, hi); end
    count_busy(n);
    checks++; if (n != 5) begin errors++; $display("FAIL mult_busy_len got %0d exp 5", n); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got %h exp fffffffa", lo); end
    issue(MD_MULTU, 32'hFFFFFFFE, 32'd3);
    count_busy(n);
    checks++; if (n != 5) begin errors++; $display("FAIL multu_busy_len got %0d exp 5", n); end
    checks++; if (hi !== 32'h00000002) begin errors++; $display("FAIL multu_hi got %h exp 00000002", hi); end
    checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_lo got %h exp fffffffa", lo); end
  endtask

  task automatic test_div;
    int n;
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    checks++; if (hi !== 32'h00000002) begin errors++; $display("FAIL div_early hi got %h exp 00000002", hi); end
    count_busy(n);
    checks++; if (n != 10) begin errors++; $display("FAIL div_busy_len got %0d exp 10", n); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", hi); end
    // 7 / -2: quotient -3, remainder +1 (sign of dividend)
    issue(MD_DIV, 32'd7, 32'hFFFFFFFE);
    count_busy(n);
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'h00000001) begin errors++; $display("FAIL div_negdiv got hi %h lo %h exp hi 00000001 lo fffffffd", hi, lo); end
    issue(MD_DIVU, 32'd7, 32'd2);
    count_busy(n);
    checks++; if (n != 10) begin errors++; $display("FAIL divu_busy_len got %0d exp 10", n); end
    checks++; if (lo !== 32'd3 || hi !== 32'd1) begin errors++; $display("FAIL divu_res got hi %h lo %h exp hi 00000001 lo 00000003", hi, lo); end
  endtask

  task automatic test_mt_divzero;
    int n;
    issue(MD_MTHI, 32'h11, 32'h0);
    checks++; if (hi !== 32'h11 || busy !== 1'b0) begin errors++; $display("FAIL mthi got hi %h busy %b exp hi 00000011 busy 0", hi, busy); end
    issue(MD_MTLO, 32'h22, 32'h0);
    checks++; if (lo !== 32'h22 || busy !== 1'b0 || hi !== 32'h11) begin errors++; $display("FAIL mtlo got hi %h lo %h busy %b exp 11 22 0", hi, lo, busy); end
    issue(MD_NOP, 32'hAAAA, 32'h0);
    issue(3'd7, 32'hBBBB, 32'h0);
    checks++; if (hi !== 32'h11 || lo !== 32'h22 || busy !== 1'b0) begin errors++; $display("FAIL nop_undef got hi %h lo %h busy %b exp 11 22 0", hi, lo, busy); end
    issue(MD_DIV, 32'd5, 32'd0);
    count_busy(n);
    checks++; if (n != 10) begin errors++; $display("FAIL divzero_busy_len got %0d exp 10", n); end
    checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL divzero_keep got hi %h lo %h exp 11 22", hi, lo); end
    issue(MD_DIVU, 32'd9, 32'd0);
    count_busy(n);
    checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL divuzero_keep got hi %h lo %h exp 11 22", hi, lo); end
  endtask

  task automatic test_stall;
    int cyc;
    int bad;
    @(negedge clk);
    d_uses_md = 1'b1;
    start = 1'b1; op = MD_MTLO; rs_val = 32'h22;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_mt got %b exp 0", stall); end
    d_uses_md = 1'b0; op = MD_MULT; rs_val = 32'd3; rt_val = 32'd4;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_no_d got %b exp 0", stall); end
    d_uses_md = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_start got %b exp 1", stall); end
    @(negedge clk);
    start = 1'b0; op = MD_NOP;
    cyc = 0;
    bad = 0;
    while (busy === 1'b1 && cyc < 50) begin
      if (cyc == 1) begin start = 1'b1; op = MD_MTHI; rs_val = 32'hDEAD; end
      else if (cyc == 2) begin start = 1'b1; op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7; end
      else begin start = 1'b0; op = MD_NOP; end
      #1;
      if (stall !== 1'b1) bad++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; op = MD_NOP;
    #1;
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_run got %0d low cycles exp 0", bad); end
    checks++; if (cyc != 5) begin errors++; $display("FAIL stall_busy_len got %0d exp 5", cyc); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_after got %b exp 0", stall); end
    checks++; if (hi !== 32'h0 || lo !== 32'd12) begin errors++; $display("FAIL ignored_start got hi %h lo %h exp 00000000 0000000c", hi, lo); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_div_busy got %b exp 0", busy); end
    d_uses_md = 1'b0;
  endtask

  task automatic test_reset_mid;
    issue(MD_MTHI, 32'h55, 32'h0);
    issue(MD_DIV, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rstmid_hilo got hi %h lo %h exp 0 0", hi, lo); end
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rstmid_late got busy %b hi %h lo %h exp 0 0 0", busy, hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt_divzero();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
